// File: rtl/rtc_disp_scan.sv
// Six-digit multiplexed display scanner: one anode at a time with a dead-time
// gap between digits, a per-frame snapshot of the segment codes, leading-zero
// suppression and a per-digit blink mask.
module rtc_disp_scan #(
  parameter int         DIGIT_CYCLES = 100_000,
  parameter int         BLANK_CYCLES = 1_000,
  parameter int         BLINK_FRAMES = 83,
  parameter logic [7:0] ZERO_CODE    = 8'hC0
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [7:0] i_seg1,
  input  logic [7:0] i_seg2,
  input  logic [7:0] i_seg3,
  input  logic [7:0] i_seg4,
  input  logic [7:0] i_seg5,
  input  logic [7:0] i_seg6,
  input  logic       i_lz_en,
  input  logic [5:0] i_blink_mask,
  output logic [7:0] o_an,
  output logic [7:0] o_seg,
  output logic       o_frame
);

  localparam int CW = $clog2((DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES) + 1;
  localparam int FW = $clog2(BLINK_FRAMES) + 1;
  localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_ON   = 2'd2
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [2:0]      idx_r, idx_nxt_s;
  logic [CW-1:0]   cnt_r, cnt_nxt_s;
  logic            capture_s;
  logic            frame_end_s;
  logic [7:0]      seg_in_s   [6];
  logic [7:0]      snap_r     [6];
  logic [7:0]      snap_nxt_s [6];
  logic [5:0]      blank_s;
  logic [FW-1:0]   frame_cnt_r;
  logic            hidden_r;
  logic [7:0]      an_r, an_nxt_s;
  logic [7:0]      seg_r, seg_nxt_s;
  logic            frame_r;

  // Next-state, dwell counter and digit index; dropping i_en always returns to IDLE
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    cnt_nxt_s   = cnt_r;
    capture_s   = 1'b0;
    frame_end_s = 1'b0;
    if (!i_en) begin
      state_nxt_s = ST_IDLE;
      idx_nxt_s   = 3'd1;
      cnt_nxt_s   = {CW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_GAP;
          idx_nxt_s   = 3'd1;
          cnt_nxt_s   = {CW{1'b0}};
        end
        ST_GAP: begin
          if (cnt_r == BLANK_LAST) begin
            state_nxt_s = ST_ON;
            cnt_nxt_s   = {CW{1'b0}};
            capture_s   = (idx_r == 3'd1);
          end else begin
            cnt_nxt_s = cnt_r + CW'(1);
          end
        end
        ST_ON: begin
          if (cnt_r == DIGIT_LAST) begin
            state_nxt_s = ST_GAP;
            cnt_nxt_s   = {CW{1'b0}};
            if (idx_r == 3'd6) begin
              idx_nxt_s   = 3'd1;
              frame_end_s = 1'b1;
            end else begin
              idx_nxt_s = idx_r + 3'd1;
            end
          end else begin
            cnt_nxt_s = cnt_r + CW'(1);
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          idx_nxt_s   = 3'd1;
          cnt_nxt_s   = {CW{1'b0}};
        end
      endcase
    end
  end

  // Snapshot seen after this edge and the per-digit blank decision built from it
  always_comb begin
    logic zero_run_v;
    zero_run_v  = 1'b1;
    seg_in_s[0] = i_seg1;
    seg_in_s[1] = i_seg2;
    seg_in_s[2] = i_seg3;
    seg_in_s[3] = i_seg4;
    seg_in_s[4] = i_seg5;
    seg_in_s[5] = i_seg6;
    for (int k = 0; k < 6; k++) begin
      snap_nxt_s[k] = capture_s ? seg_in_s[k] : snap_r[k];
    end
    for (int d = 0; d < 6; d++) begin
      zero_run_v = 1'b1;
      for (int k = d; k < 6; k++) begin
        zero_run_v = zero_run_v & (snap_nxt_s[k] == ZERO_CODE);
      end
      // digit 1 (d == 0) is never zero-suppressed
      blank_s[d] = (hidden_r & i_blink_mask[d]) | (i_lz_en & (d >= 1) & zero_run_v);
    end
  end

  // Anode and segment values that go with the next state
  always_comb begin
    an_nxt_s  = 8'hFF;
    seg_nxt_s = 8'hFF;
    if (state_nxt_s == ST_ON) begin
      case (idx_nxt_s)
        3'd1: begin an_nxt_s = 8'hFE; seg_nxt_s = blank_s[0] ? 8'hFF : snap_nxt_s[0]; end
        3'd2: begin an_nxt_s = 8'hFD; seg_nxt_s = blank_s[1] ? 8'hFF : snap_nxt_s[1]; end
        3'd3: begin an_nxt_s = 8'hFB; seg_nxt_s = blank_s[2] ? 8'hFF : snap_nxt_s[2]; end
        3'd4: begin an_nxt_s = 8'hF7; seg_nxt_s = blank_s[3] ? 8'hFF : snap_nxt_s[3]; end
        3'd5: begin an_nxt_s = 8'hEF; seg_nxt_s = blank_s[4] ? 8'hFF : snap_nxt_s[4]; end
        3'd6: begin an_nxt_s = 8'hDF; seg_nxt_s = blank_s[5] ? 8'hFF : snap_nxt_s[5]; end
        default: begin an_nxt_s = 8'hFF; seg_nxt_s = 8'hFF; end
      endcase
    end else begin
      an_nxt_s  = 8'hFF;
      seg_nxt_s = 8'hFF;
    end
  end

  // Scan state, counter and index registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
      idx_r   <= 3'd1;
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Frame snapshot, frame counter and blink phase; all cleared while disabled
  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      for (int k = 0; k < 6; k++) snap_r[k] <= 8'hFF;
      frame_cnt_r <= {FW{1'b0}};
      hidden_r    <= 1'b0;
    end else begin
      for (int k = 0; k < 6; k++) snap_r[k] <= snap_nxt_s[k];
      if (frame_end_s) begin
        if (frame_cnt_r == FRAME_LAST) begin
          frame_cnt_r <= {FW{1'b0}};
          hidden_r    <= ~hidden_r;
        end else begin
          frame_cnt_r <= frame_cnt_r + FW'(1);
        end
      end else begin
        frame_cnt_r <= frame_cnt_r;
        hidden_r    <= hidden_r;
      end
    end
  end

  // Registered display outputs, updated on the same edge as the state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      an_r    <= 8'hFF;
      seg_r   <= 8'hFF;
      frame_r <= 1'b0;
    end else begin
      an_r    <= an_nxt_s;
      seg_r   <= seg_nxt_s;
      frame_r <= frame_end_s;
    end
  end

  assign o_an    = an_r;
  assign o_seg   = seg_r;
  assign o_frame = frame_r;

endmodule
